corr_readout_master: RTL and testbench

- Register-bus initiator that reads correlator accumulator registers; the correlator channels are the responders on that bus.
- On each `start` (the accumulation interrupt), it reads a fixed window of registers from every channel in address order.
- Returned words pass through an internal FIFO into a valid/ready stream toward DMA, preceded by a one-word frame header.
- Sits beside the correlator on the same `reg_addr`/`rd_en`/`rdata` bus, muxed ahead of the CPU port.

---
 rtl/corr_readout_master_if.sv | 13 +
 rtl/corr_readout_master.sv | 164 ++++++++++++++++
 tb/tb_corr_readout_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/corr_readout_master_if.sv
// Register-bus read port plus DMA-side valid/ready stream of the correlator readout master.
interface corr_readout_master_if #(parameter int ADDR_WIDTH = 16);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [31:0]           rdata;
   logic [31:0]           m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (output rd_en, reg_addr, m_data, m_valid, m_last, input rdata, m_ready);
   modport slave  (input rd_en, reg_addr, m_data, m_valid, m_last, output rdata, m_ready);
endinterface

// File: rtl/corr_readout_master.sv
// Frame readout initiator: on each start, reads a register window from every correlator
// channel and streams a header word plus the returned data toward DMA through a FWFT FIFO.
module corr_readout_master #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h8000,
   parameter int                    CHANNELS    = 8,
   parameter int                    CH_SHIFT    = 6,
   parameter int                    REG_OFFSET  = 4,
   parameter int                    REGS_PER_CH = 4,
   parameter int                    RD_LAT      = 1,
   parameter int                    FIFO_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   corr_readout_master_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun,
   output logic [15:0]           frame_cnt
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int R_W   = (REGS_PER_CH > 1) ? $clog2(REGS_PER_CH) : 1;
   localparam logic [CNT_W:0]   DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_L  = CNT_W'(FIFO_DEPTH);
   localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);
   localparam logic [R_W-1:0]   R_LAST  = R_W'(REGS_PER_CH - 1);

   typedef enum logic [1:0] {IDLE, HDR, ISSUE, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  overrun_q, overrun_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [R_W-1:0]        r_q, r_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      outst_q, outst_d;
   logic [RD_LAT-1:0]     tag_q, tag_d, tag_last_q, tag_last_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [32:0]           mem [FIFO_DEPTH];

   logic [ADDR_WIDTH-1:0] cur_addr;
   logic                  issue, last_rd, data_push, final_push, push, pop, accept, busy_c;
   logic                  fifo_valid;
   logic [32:0]           push_word;

   always_comb begin
      cur_addr   = BASE_ADDR + (ADDR_WIDTH'(ch_q) << CH_SHIFT) + ADDR_WIDTH'(REG_OFFSET)
                 + ADDR_WIDTH'(r_q);
      last_rd    = (ch_q == CH_LAST) && (r_q == R_LAST);
      data_push  = tag_q[RD_LAT-1];
      final_push = data_push & tag_last_q[RD_LAT-1];
      fifo_valid = (count_q != '0);
      pop        = fifo_valid & bus.m_ready;
      // busy drops in the cycle the final data word is written, so a start there is accepted
      busy_c     = (state_q != IDLE) & ~final_push;
      accept     = start & ~busy_c;
      // credit: every issued read already owns a FIFO slot, so returns never see a full FIFO
      issue      = (state_q == ISSUE) && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_L);
      push       = data_push;
      push_word  = {tag_last_q[RD_LAT-1], bus.rdata};

      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      ch_d        = ch_q;
      r_d         = r_q;
      addr_d      = addr_q;
      overrun_d   = overrun_q | (start & busy_c);

      case (state_q)
         HDR: begin
            if ((count_q != FULL_L) || pop) begin
               push      = 1'b1;
               push_word = {1'b0, 16'hA5C0, frame_cnt_q};
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (issue) begin
               addr_d = cur_addr;
               if (r_q == R_LAST) begin
                  r_d  = '0;
                  ch_d = ch_q + CH_W'(1);
               end else begin
                  r_d = r_q + R_W'(1);
               end
               if (last_rd) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (final_push) state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         state_d     = HDR;
         frame_cnt_d = frame_cnt_q + 16'd1;
         ch_d        = '0;
         r_d         = '0;
      end

      tag_d      = (tag_q << 1) | RD_LAT'(issue);
      tag_last_d = (tag_last_q << 1) | RD_LAT'(issue & last_rd);

      outst_d = outst_q;
      if (issue && !data_push)      outst_d = outst_q + CNT_W'(1);
      else if (!issue && data_push) outst_d = outst_q - CNT_W'(1);

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
         ch_q        <= '0;
         r_q         <= '0;
         addr_q      <= '0;
         outst_q     <= '0;
         tag_q       <= '0;
         tag_last_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
         ch_q        <= ch_d;
         r_q         <= r_d;
         addr_q      <= addr_d;
         outst_q     <= outst_d;
         tag_q       <= tag_d;
         tag_last_q  <= tag_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_word;
   end

   assign bus.rd_en    = issue;
   assign bus.reg_addr = issue ? cur_addr : addr_q;
   assign bus.m_valid  = fifo_valid;
   assign bus.m_data   = fifo_valid ? mem[rd_ptr_q][31:0] : 32'h0;
   assign bus.m_last   = fifo_valid & mem[rd_ptr_q][32];
   assign busy         = busy_c;
   assign done         = final_push;
   assign overrun      = overrun_q;
   assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_corr_readout_master.sv
// Directed bench for corr_readout_master: RD_LAT=1 instance for most steps, RD_LAT=3 for latency.
module tb_corr_readout_master;
   logic        clk = 1'b0;
   logic        reset, start0, start3;
   logic        busy0, done0, overrun0, busy3, done3, overrun3;
   logic [15:0] fc0, fc3;

   corr_readout_master_if #(.ADDR_WIDTH(16)) bus0 ();
   corr_readout_master_if #(.ADDR_WIDTH(16)) bus3 ();

   corr_readout_master dut0 (
      .clk(clk), .reset(reset), .start(start0), .bus(bus0),
      .busy(busy0), .done(done0), .overrun(overrun0), .frame_cnt(fc0)
   );

   corr_readout_master #(.RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .bus(bus3),
      .busy(busy3), .done(done3), .overrun(overrun3), .frame_cnt(fc3)
   );

   always #5 clk = ~clk;

   // responders return the read address as data, garbage when no read is due
   logic [31:0] p3_a, p3_b;
   always @(posedge clk) begin
      bus0.rdata <= bus0.rd_en ? {16'h0, bus0.reg_addr} : 32'hBAD0_0000;
      p3_a       <= bus3.rd_en ? {16'h0, bus3.reg_addr} : 32'hBAD0_0003;
      p3_b       <= p3_a;
      bus3.rdata <= p3_b;
   end

   logic [32:0] got0[$];
   logic [32:0] got3[$];
   logic [32:0] exp0[$];
   int rd_cnt0 = 0, done_cnt0 = 0, busy_cnt0 = 0, max_out3 = 0;

   always @(negedge clk) begin
      if (bus0.m_valid && bus0.m_ready) got0.push_back({bus0.m_last, bus0.m_data});
      if (bus3.m_valid && bus3.m_ready) got3.push_back({bus3.m_last, bus3.m_data});
      if (bus0.rd_en) rd_cnt0++;
      if (done0) done_cnt0++;
      if (busy0) busy_cnt0++;
      if (int'(dut3.outst_q) > max_out3) max_out3 = int'(dut3.outst_q);
   end

   int n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_frame(input logic [15:0] n);
      logic [31:0] w;
      exp0.push_back({1'b0, 16'hA5C0, n});
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < 4; r++) begin
            w = 32'h8000 + 32'(c * 64 + 4 + r);
            exp0.push_back({(c == 7 && r == 3), w});
         end
      end
   endtask

   task automatic cmp(input string tag, input logic [32:0] got[$], input logic [32:0] exp[$]);
      $display("frame %s: %0d words received, %0d expected", tag, got.size(), exp.size());
      chk({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
   endtask

   task automatic wait_done0(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done0) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk(tag, seen, 1);
   endtask

   task automatic drain0(input string tag);
      tick();
      for (int i = 0; i < 60; i++) begin
         if (!bus0.m_valid) break;
         tick();
      end
      chk(tag, bus0.m_valid, 0);
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, "_rd_en"}, bus0.rd_en, 0);
      chk({tag, "_reg_addr"}, bus0.reg_addr, 0);
      chk({tag, "_m_valid"}, bus0.m_valid, 0);
      chk({tag, "_m_data"}, bus0.m_data, 0);
      chk({tag, "_m_last"}, bus0.m_last, 0);
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_done"}, done0, 0);
      chk({tag, "_overrun"}, overrun0, 0);
      chk({tag, "_frame_cnt"}, fc0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rd_base, done_base, busy_base, di;
      bit seen3;
      logic [31:0] held;

      reset = 1'b1; start0 = 1'b0; start3 = 1'b0;
      bus0.m_ready = 1'b0; bus3.m_ready = 1'b0;
      repeat (3) tick();
      chk_zero0("rst");
      reset = 1'b0;
      tick();

      // frame 1, free-flowing stream
      bus0.m_ready = 1'b1;
      rd_base = rd_cnt0; done_base = done_cnt0; busy_base = busy_cnt0;
      start0 = 1'b1;
      chk("s1_busy_before", busy0, 0);
      tick();
      start0 = 1'b0;
      chk("s1_busy_rise", busy0, 1);
      chk("s1_frame_cnt", fc0, 1);
      add_frame(16'd1);
      wait_done0("s1_done_seen");
      chk("s1_busy_low_at_done", busy0, 0);
      drain0("s1_drain");
      chk("s1_reads", rd_cnt0 - rd_base, 32);
      chk("s1_done_pulses", done_cnt0 - done_base, 1);
      chk("s1_busy_cycles", busy_cnt0 - busy_base, 33);
      cmp("s1", got0, exp0);
      got0.delete(); exp0.delete();

      // frame 2 with the stream stalled
      bus0.m_ready = 1'b0;
      rd_base = rd_cnt0;
      start0 = 1'b1; tick(); start0 = 1'b0;
      repeat (40) tick();
      chk("s2_stall_reads", rd_cnt0 - rd_base, 15);
      chk("s2_stall_valid", bus0.m_valid, 1);
      chk("s2_stall_data", bus0.m_data, 32'hA5C0_0002);
      chk("s2_stall_last", bus0.m_last, 0);
      chk("s2_stall_busy", busy0, 1);
      held = bus0.m_data;
      tick();
      chk("s2_stall_hold", held, bus0.m_data);
      bus0.m_ready = 1'b1;
      add_frame(16'd2);
      wait_done0("s2_done_seen");
      drain0("s2_drain");
      chk("s2_reads", rd_cnt0 - rd_base, 32);
      cmp("s2", got0, exp0);
      got0.delete(); exp0.delete();

      // frame 3 hit by a start mid-frame, frame 4 started in the done cycle
      start0 = 1'b1; tick(); start0 = 1'b0;
      repeat (4) tick();
      chk("s4_overrun_before", overrun0, 0);
      start0 = 1'b1; tick(); start0 = 1'b0;
      chk("s4_overrun_set", overrun0, 1);
      chk("s4_frame_cnt_kept", fc0, 3);
      chk("s4_still_busy", busy0, 1);
      add_frame(16'd3);
      wait_done0("s4_done3_seen");
      chk("s4_busy_low_at_done", busy0, 0);
      start0 = 1'b1; tick(); start0 = 1'b0;
      chk("s4_start_at_done_busy", busy0, 1);
      chk("s4_start_at_done_cnt", fc0, 4);
      add_frame(16'd4);
      wait_done0("s4_done4_seen");
      drain0("s4_drain");
      chk("s4_overrun_sticky", overrun0, 1);
      cmp("s4", got0, exp0);
      got0.delete(); exp0.delete();

      // asynchronous reset in the middle of issuing reads
      start0 = 1'b1; tick(); start0 = 1'b0;
      repeat (10) tick();
      chk("s5_issuing", bus0.rd_en, 1);
      #2 reset = 1'b1;
      #1;
      chk_zero0("s5_async");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) tick();
      got0.delete();
      chk("s5_fifo_empty", bus0.m_valid, 0);
      start0 = 1'b1; tick(); start0 = 1'b0;
      add_frame(16'd1);
      wait_done0("s5_done_seen");
      drain0("s5_drain");
      cmp("s5", got0, exp0);
      got0.delete(); exp0.delete();

      // RD_LAT=3 with the stream ready every other cycle
      got3.delete();
      start3 = 1'b1; tick(); start3 = 1'b0;
      seen3 = 1'b0; di = 0;
      for (int i = 0; i < 400; i++) begin
         if (done3 && !seen3) begin
            seen3 = 1'b1;
            di = i;
         end
         if (seen3 && i > di && !bus3.m_valid) break;
         bus3.m_ready = ~bus3.m_ready;
         tick();
      end
      bus3.m_ready = 1'b0;
      chk("s3_done_seen", seen3, 1);
      chk("s3_max_outstanding_le3", (max_out3 <= 3), 1);
      chk("s3_frame_cnt", fc3, 1);
      chk("s3_busy_idle", busy3, 0);
      chk("s3_overrun", overrun3, 0);
      add_frame(16'd1);
      cmp("s3", got3, exp0);
      got3.delete(); exp0.delete();

      // frame counter wrap
      force dut0.frame_cnt_q = 16'hFFFF;
      tick();
      release dut0.frame_cnt_q;
      tick();
      chk("s6_preload", fc0, 16'hFFFF);
      start0 = 1'b1; tick(); start0 = 1'b0;
      chk("s6_wrap_cnt", fc0, 0);
      add_frame(16'd0);
      wait_done0("s6_done_seen");
      drain0("s6_drain");
      cmp("s6", got0, exp0);
      got0.delete(); exp0.delete();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
